// File: rtl/triple_port_mem_ctrl_if.sv
// Bus bundle for triple_port_mem_ctrl: read request/response, write-back, and memory-side ports.
// The slave modport is the controller; the master modport is the requester plus memory.
interface triple_port_mem_ctrl_if #(
  parameter int DATAW = 32,
  parameter int ADDRW = 6
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [ADDRW-1:0] req_addr_1_i;
  logic [ADDRW-1:0] req_addr_2_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [DATAW-1:0] rsp_data_1_o;
  logic [DATAW-1:0] rsp_data_2_o;
  logic             wb_valid_i;
  logic [ADDRW-1:0] wb_addr_i;
  logic [DATAW-1:0] wb_data_i;
  logic             mem_wren_o;
  logic [ADDRW-1:0] mem_waddr_o;
  logic [DATAW-1:0] mem_wdata_o;
  logic [ADDRW-1:0] mem_raddr_1_o;
  logic [ADDRW-1:0] mem_raddr_2_o;
  logic [DATAW-1:0] mem_rdata_1_i;
  logic [DATAW-1:0] mem_rdata_2_i;

  modport slave (
    input  req_valid_i, req_addr_1_i, req_addr_2_i, rsp_ready_i,
           wb_valid_i, wb_addr_i, wb_data_i, mem_rdata_1_i, mem_rdata_2_i,
    output req_ready_o, rsp_valid_o, rsp_data_1_o, rsp_data_2_o,
           mem_wren_o, mem_waddr_o, mem_wdata_o, mem_raddr_1_o, mem_raddr_2_o
  );

  modport master (
    output req_valid_i, req_addr_1_i, req_addr_2_i, rsp_ready_i,
           wb_valid_i, wb_addr_i, wb_data_i, mem_rdata_1_i, mem_rdata_2_i,
    input  req_ready_o, rsp_valid_o, rsp_data_1_o, rsp_data_2_o,
           mem_wren_o, mem_waddr_o, mem_wdata_o, mem_raddr_1_o, mem_raddr_2_o
  );
endinterface

// File: rtl/triple_port_mem_ctrl.sv
// Two-operand read controller over a 1W/2R memory with pass-through write-back port.
// Define TPM_CTRL_WB_BYPASS_EN to forward write-backs that land after the request accept.
module triple_port_mem_ctrl #(
  parameter int DATAW   = 32,
  parameter int SIZE    = 64,
  parameter int ADDRW   = $clog2(SIZE),
  parameter int MEM_LAT = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  triple_port_mem_ctrl_if.slave bus
);
  localparam int NUM_OPS = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0] state_q, state_d;
  logic       accept, capture, in_resp;

  logic [NUM_OPS-1:0][ADDRW-1:0] req_addr, raddr;
  logic [NUM_OPS-1:0][DATAW-1:0] rdata, rsp_data;

  assign req_addr = {bus.req_addr_2_i, bus.req_addr_1_i};
  assign rdata    = {bus.mem_rdata_2_i, bus.mem_rdata_1_i};

  // Write path never stalls; it only depends on reset.
  assign bus.mem_wren_o  = bus.wb_valid_i & ~rst_i;
  assign bus.mem_waddr_o = bus.wb_addr_i;
  assign bus.mem_wdata_o = bus.wb_data_i;

  assign in_resp         = (state_q == RESP);
  assign bus.req_ready_o = (state_q == IDLE) | (in_resp & bus.rsp_ready_i);
  assign bus.rsp_valid_o = in_resp;
  assign accept          = bus.req_valid_i & bus.req_ready_o;
  // Last cycle before RESP is where memory data is sampled.
  assign capture         = (MEM_LAT == 0) ? (state_q == READ) : (state_q == WAIT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = (MEM_LAT == 0) ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = accept ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [DATAW-1:0] data_q, data_d;

    always_comb begin
      addr_d = accept ? req_addr[i] : addr_q;
    end

`ifdef TPM_CTRL_WB_BYPASS_EN
    logic             wr_hit;
    logic             byp_vld_q, byp_vld_d;
    logic [DATAW-1:0] byp_data_q, byp_data_d;

    assign wr_hit = bus.wb_valid_i & (bus.wb_addr_i == addr_q);

    always_comb begin
      byp_vld_d  = byp_vld_q;
      byp_data_d = byp_data_q;
      data_d     = data_q;
      if (accept) begin
        byp_vld_d = 1'b0;
      end else if (wr_hit && (state_q == READ || state_q == WAIT)) begin
        byp_vld_d  = 1'b1;
        byp_data_d = bus.wb_data_i;
      end
      // Newest write beats pending bypass, which beats memory data.
      if (capture)
        data_d = wr_hit ? bus.wb_data_i : (byp_vld_q ? byp_data_q : rdata[i]);
      else if (in_resp && !bus.rsp_ready_i && wr_hit)
        data_d = bus.wb_data_i;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        byp_vld_q  <= 1'b0;
        byp_data_q <= '0;
      end else begin
        byp_vld_q  <= byp_vld_d;
        byp_data_q <= byp_data_d;
      end
    end
`else
    always_comb begin
      data_d = capture ? rdata[i] : data_q;
    end
`endif

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        addr_q <= '0;
        data_q <= '0;
      end else begin
        addr_q <= addr_d;
        data_q <= data_d;
      end
    end

    assign raddr[i]    = addr_q;
    assign rsp_data[i] = data_q;
  end

  assign bus.mem_raddr_1_o = raddr[0];
  assign bus.mem_raddr_2_o = raddr[1];
  assign bus.rsp_data_1_o  = rsp_data[0];
  assign bus.rsp_data_2_o  = rsp_data[1];
endmodule
